// File: rtl/hps_io_master.sv
// hps_io_master
// FPGA-side initiator for the HPS I/O word bus. On-chip logic offers
// 16-bit command words. Each word is driven onto io_din under a frame
// enable, strobed with io_clk, and completed through the io_ack level
// handshake. The responder's io_dout/io_wide come back as a response.
//
// Ports
//   clk_sys, reset      system clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_sel (0 close, 1 fpga,
//                       2 osd, 3 uio), cmd_data, cmd_end (close after word)
//   rsp_valid           one-cycle pulse per finished or aborted word
//   rsp_data/wide       io_dout/io_wide captured when ack was seen high
//   rsp_timeout         qualifies rsp_valid: word aborted
//   busy                master not idle
//   io_din, io_clk      bus data and strobe level
//   io_fpga/osd/uio     frame enables, at most one high
//   io_ack, io_dout,    responder acknowledge, read data, width flag
//   io_wide
module hps_io_master #(
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_sel,
    input  logic [15:0] cmd_data,
    input  logic        cmd_end,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_wide,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] io_din,
    output logic        io_clk,
    output logic        io_fpga,
    output logic        io_osd,
    output logic        io_uio,
    input  logic        io_ack,
    input  logic [15:0] io_dout,
    input  logic        io_wide
);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT_HI, WAIT_LO, GAP} state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  frame_q, frame_d;
    logic [2:0]  en_q, en_d;
    logic        end_q, end_d;
    // Set while a frame close is in progress: holds off cmd_ready and
    // tells GAP to return to IDLE instead of opening a new frame.
    logic        gap_q, gap_d;
    logic [15:0] din_q, din_d;
    logic        clk_q, clk_d;
    logic        ready_q, ready_d;
    logic        rvld_q, rvld_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rwide_q, rwide_d;
    logic        rto_q, rto_d;
    logic        busy_q, busy_d;
    logic        timed_out;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            2'd1:    sel_onehot = 3'b001;
            2'd2:    sel_onehot = 3'b010;
            2'd3:    sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    endfunction

    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        frame_d = frame_q;
        en_d    = en_q;
        end_d   = end_q;
        gap_d   = gap_q;
        din_d   = din_q;
        clk_d   = clk_q;
        ready_d = ready_q;
        rvld_d  = 1'b0;
        rdata_d = rdata_q;
        rwide_d = rwide_q;
        rto_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = ~io_ack & ~gap_q;
                if (gap_q) begin
                    // Frame close after the last word: drop enables now.
                    en_d    = 3'b000;
                    frame_d = 2'd0;
                    ready_d = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = GAP;
                end else if (cmd_valid && ready_q) begin
                    if (cmd_sel == 2'd0) begin
                        if (frame_q != 2'd0) begin
                            en_d    = 3'b000;
                            frame_d = 2'd0;
                            gap_d   = 1'b1;
                            ready_d = 1'b0;
                            cnt_d   = 16'd0;
                            state_d = GAP;
                        end
                    end else begin
                        din_d   = cmd_data;
                        end_d   = cmd_end;
                        frame_d = cmd_sel;
                        ready_d = 1'b0;
                        cnt_d   = 16'd0;
                        if (frame_q != 2'd0 && frame_q != cmd_sel) begin
                            // Frame switch: one cycle with no enable first.
                            en_d    = 3'b000;
                            gap_d   = 1'b0;
                            state_d = GAP;
                        end else begin
                            en_d    = sel_onehot(cmd_sel);
                            state_d = SETUP;
                        end
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    clk_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (io_ack) begin
                    rdata_d = io_dout;
                    rwide_d = io_wide;
                    clk_d   = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = WAIT_LO;
                end else if (timed_out) begin
                    clk_d   = 1'b0;
                    en_d    = 3'b000;
                    frame_d = 2'd0;
                    gap_d   = 1'b0;
                    rvld_d  = 1'b1;
                    rto_d   = 1'b1;
                    rdata_d = 16'd0;
                    rwide_d = 1'b0;
                    ready_d = ~io_ack;
                    state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (!io_ack) begin
                    rvld_d  = 1'b1;
                    gap_d   = end_q;
                    ready_d = ~end_q;
                    state_d = IDLE;
                end else if (timed_out) begin
                    clk_d   = 1'b0;
                    en_d    = 3'b000;
                    frame_d = 2'd0;
                    gap_d   = 1'b0;
                    rvld_d  = 1'b1;
                    rto_d   = 1'b1;
                    rdata_d = 16'd0;
                    rwide_d = 1'b0;
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            GAP: begin
                cnt_d = 16'd0;
                if (gap_q) begin
                    gap_d   = 1'b0;
                    ready_d = ~io_ack;
                    state_d = IDLE;
                end else begin
                    en_d    = sel_onehot(frame_q);
                    state_d = SETUP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            frame_q <= 2'd0;
            en_q    <= 3'b000;
            end_q   <= 1'b0;
            gap_q   <= 1'b0;
            din_q   <= 16'd0;
            clk_q   <= 1'b0;
            ready_q <= 1'b0;
            rvld_q  <= 1'b0;
            rdata_q <= 16'd0;
            rwide_q <= 1'b0;
            rto_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            en_q    <= en_d;
            end_q   <= end_d;
            gap_q   <= gap_d;
            din_q   <= din_d;
            clk_q   <= clk_d;
            ready_q <= ready_d;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
            rwide_q <= rwide_d;
            rto_q   <= rto_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rvld_q;
    assign rsp_data    = rdata_q;
    assign rsp_wide    = rwide_q;
    assign rsp_timeout = rto_q;
    assign busy        = busy_q;
    assign io_din      = din_q;
    assign io_clk      = clk_q;
    assign io_fpga     = en_q[0];
    assign io_osd      = en_q[1];
    assign io_uio      = en_q[2];

endmodule

// File: doc/hps_io_master.md
# hps_io_master

FPGA-side initiator for the HPS I/O word bus. It drives io_din, io_clk and the io_fpga/io_osd/io_uio frame enables, and waits on the io_ack level handshake. It lets on-chip logic (boot-time OSD/UIO injectors, self-test, simulation stimulus) issue 16-bit command words to the existing responders exactly as the HPS does. Each completed word returns the responder's io_dout/io_wide as a response.

## Interface
- SETUP_CYC, 1: cycles io_din/enable are held stable before io_clk rises (1..15).
- TIMEOUT, 4095: max cycles spent in one ack-wait state before abort; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock, same domain as the responder's io_ack register
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command word offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_sel  in  2  target: 0 = close frame only, 1 = fpga, 2 = osd, 3 = uio
- cmd_data  in  16  word to send
- cmd_end  in  1  close the frame after this word
- rsp_valid  out  1  one-cycle pulse per finished word or timeout
- rsp_data  out  16  io_dout captured at ack-high
- rsp_wide  out  1  io_wide captured at ack-high
- rsp_timeout  out  1  qualifies rsp_valid: word aborted
- busy  out  1  state != IDLE
- io_din  out  16  bus data
- io_clk  out  1  bus strobe level
- io_fpga, io_osd, io_uio  out  1 each  frame enables, at most one high
- io_ack  in  1  responder acknowledge level
- io_dout  in  16  responder read data
- io_wide  in  1  responder width flag

## Operation
- All outputs are registered. Reset values: io_clk=0, all enables 0, io_din=0, cmd_ready=0, rsp_*=0, busy=0, frame=none, state=IDLE.
- States:
  - IDLE: cmd_ready = (io_ack==0) & ~gap.
  - SETUP: counter counts SETUP_CYC cycles.
  - WAIT_HI: io_clk=1, wait for io_ack==1.
  - WAIT_LO: io_clk=0, wait for io_ack==0.
  - GAP: one cycle with all enables 0.
- Accept with cmd_sel=0: if a frame is open, drop the enables and go to GAP, then IDLE. Otherwise do nothing. No response either way.
- Accept with cmd_sel!=0 while a different frame is open: drop the enables for 1 GAP cycle, then raise the new enable. The open frame is not closed otherwise.
- Accept with cmd_sel!=0 otherwise:
  - Latch cmd_data and cmd_end, drive io_din, assert the selected enable, enter SETUP.
  - After SETUP, raise io_clk in WAIT_HI.
  - On the first cycle with io_ack==1: capture io_dout/io_wide, then drop io_clk and enter WAIT_LO.
  - On io_ack==0: pulse rsp_valid. If cmd_end, drop the enables and go to GAP, then IDLE. Otherwise go to IDLE with the frame held open.
- io_din holds its value until the next accepted word; it never changes while io_clk=1.
- Timeout: a wait counter resets on each state entry. If it reaches TIMEOUT in WAIT_HI or WAIT_LO:
  - force io_clk=0 and enables=0, set frame=none;
  - pulse rsp_valid with rsp_timeout=1 and rsp_data=0;
  - go to IDLE.
- Because IDLE requires io_ack==0 before accepting, a stuck-high ack blocks further commands.
- An io_wait stall on the responder only lengthens the waits; the master tolerates an arbitrary stall below TIMEOUT.

## Timing
- Ack latency with a standard two-register responder and io_wait=0, SETUP_CYC=1, accept at T0:
  - T1: io_din and enable valid.
  - T2: io_clk=1.
  - T4: io_ack=1 seen.
  - T5: io_clk=0.
  - T7: io_ack=0 seen.
  - T8: rsp_valid.
- Words per frame cost 8 cycles each; the next word can be accepted at T8.
- A frame close adds 1 GAP cycle, so cmd_ready is next high at T10 (T9 GAP).
- SETUP_CYC=n shifts every later edge by n-1 cycles.
- The responder sees exactly one io_strobe per word, in cycle T2 (rising io_clk against its rack).
- Asynchronous reset mid-transaction returns all outputs to reset values immediately. No response is emitted.

## Test plan
- Single OSD word: cmd_sel=2, data=0x0041, end=1, loopback responder with io_dout=0x1234, io_wide=1 → io_osd high T1..T8, io_clk high T2..T4, rsp_valid at T8 with 0x1234/wide=1, io_osd low at T9, cmd_ready high at T10.
- Three-word UIO frame, end only on the last word → io_uio stays high continuously with no GAP between words; three io_strobe pulses in the responder; three responses matching io_dout per word.
- Frame switch: fpga word (end=0), then osd word → exactly 1 cycle with all enables low between the frames; never two enables high together.
- Responder io_wait held for 20 cycles during WAIT_HI, TIMEOUT=4095 → completion delayed by 20 cycles; rsp_timeout=0.
- io_ack tied 0, TIMEOUT=16 → rsp_valid with rsp_timeout=1 sixteen cycles into WAIT_HI; io_clk and enables 0; next command accepted.
- reset asserted at T3 → io_clk, enables and busy drop in the same cycle; no rsp_valid; a fresh command after release completes normally.
